// File: rtl/alu_seq.sv
// Sequencer around an external combinational ALU: owns W, an 8x8 register file and C/Z flags,
// and retires one instruction every three cycles (IDLE -> EXEC -> WB).
module alu_seq #(
  parameter logic [7:0] RESET_W = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [13:0] in_instr,
  output logic        in_ready,
  output logic [3:0]  alu_inst,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [2:0]  alu_bit,
  input  logic [7:0]  alu_ans,
  input  logic        alu_carry,
  output logic [7:0]  w_out,
  output logic        c_flag,
  output logic        z_flag,
  output logic        illegal,
  input  logic [2:0]  dbg_addr,
  output logic [7:0]  dbg_data,
  output logic        done
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB} state_t;

  localparam logic [3:0] OP_NOP  = 4'd8;
  localparam logic [3:0] OP_BCLR = 4'd13;
  localparam logic [3:0] OP_BSET = 4'd14;
  localparam logic [3:0] OP_ILL  = 4'd15;

  state_t      r_state;
  logic [3:0]  r_op;
  logic        r_d;
  logic [2:0]  r_bit;
  logic [2:0]  r_fa;
  logic [7:0]  r_w;
  logic [7:0]  r_f [8];
  logic        r_c;
  logic        r_z;
  logic        r_ill;
  logic        r_done;
  logic        r_ready;
  logic [3:0]  r_alu_inst;
  logic [2:0]  r_alu_bit;
  logic [7:0]  r_res;
  logic        r_carry;

  logic [7:0]  w_fsel;
  logic [7:0]  w_mask;
  logic [7:0]  w_res_exec;
  logic        w_writes;
  logic        w_upd_c;
  logic        w_unused;

  // Instruction bits [5:3] carry no meaning for this block.
  assign w_unused = ^in_instr[5:3];

  assign w_fsel = r_f[r_fa];
  assign w_mask = 8'd1 << r_bit;

  always_comb begin
    w_res_exec = alu_ans;
    if (r_op == OP_BCLR)      w_res_exec = w_fsel & ~w_mask;
    else if (r_op == OP_BSET) w_res_exec = w_fsel | w_mask;
  end

  assign w_writes = (r_op != OP_NOP) && (r_op != OP_ILL);
  assign w_upd_c  = (r_op == 4'd2) || (r_op == 4'd3) || (r_op == 4'd5) || (r_op == 4'd6);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_op       <= OP_NOP;
      r_d        <= 1'b0;
      r_bit      <= 3'd0;
      r_fa       <= 3'd0;
      r_w        <= RESET_W;
      for (int i = 0; i < 8; i++) r_f[i] <= 8'h00;
      r_c        <= 1'b0;
      r_z        <= 1'b0;
      r_ill      <= 1'b0;
      r_done     <= 1'b0;
      r_ready    <= 1'b1;
      r_alu_inst <= OP_NOP;
      r_alu_bit  <= 3'd0;
      r_res      <= 8'h00;
      r_carry    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_op       <= in_instr[13:10];
            r_d        <= in_instr[9];
            r_bit      <= in_instr[8:6];
            r_fa       <= in_instr[2:0];
            r_alu_inst <= in_instr[13:10];
            r_alu_bit  <= in_instr[8:6];
            r_ready    <= 1'b0;
            r_state    <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_res      <= w_res_exec;
          r_carry    <= alu_carry;
          r_alu_inst <= OP_NOP;
          r_alu_bit  <= 3'd0;
          r_done     <= 1'b1;
          r_state    <= S_WB;
        end
        S_WB: begin
          // Commit at the end of WB so readers see the old value during WB.
          if (w_writes) begin
            if (r_d) r_f[r_fa] <= r_res;
            else     r_w       <= r_res;
            r_z <= (r_res == 8'h00);
          end
          if (w_upd_c)        r_c   <= r_carry;
          if (r_op == OP_ILL) r_ill <= 1'b1;
          r_done  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready = r_ready;
  assign alu_inst = r_alu_inst;
  assign alu_bit  = r_alu_bit;
  assign alu_a    = r_w;
  assign alu_b    = (r_state == S_EXEC) ? w_fsel : r_f[0];
  assign w_out    = r_w;
  assign c_flag   = r_c;
  assign z_flag   = r_z;
  assign illegal  = r_ill;
  assign done     = r_done;
  assign dbg_data = r_f[dbg_addr];

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: behavioural external ALU, a small architectural model,
// and hand-computed checks for add, borrow, inc wrap, bset/bclr, illegal, back-pressure and reset abort.
module tb_alu_seq;

  localparam logic [7:0] RST_W = 8'hA5;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [13:0] in_instr;
  logic        in_ready;
  logic [3:0]  alu_inst;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [2:0]  alu_bit;
  logic [7:0]  alu_ans;
  logic        alu_carry;
  logic [7:0]  w_out;
  logic        c_flag;
  logic        z_flag;
  logic        illegal;
  logic [2:0]  dbg_addr;
  logic [7:0]  dbg_data;
  logic        done;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] m_w;
  logic [7:0] m_f [8];
  logic       m_c, m_z, m_ill;

  alu_seq #(.RESET_W(RST_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_instr(in_instr),
    .in_ready(in_ready), .alu_inst(alu_inst), .alu_a(alu_a), .alu_b(alu_b),
    .alu_bit(alu_bit), .alu_ans(alu_ans), .alu_carry(alu_carry), .w_out(w_out),
    .c_flag(c_flag), .z_flag(z_flag), .illegal(illegal), .dbg_addr(dbg_addr),
    .dbg_data(dbg_data), .done(done)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: 0 movf, 1 movw, 2 add, 3 sub F-W, 4 and, 5 inc, 6 dec, 7 or, 9 xor, 10 comf.
  function automatic logic [8:0] alu_fn(input logic [3:0] op, input logic [7:0] a,
                                        input logic [7:0] b, input logic [2:0] bt);
    logic [8:0] r;
    case (op)
      4'd0:    r = {1'b0, b};
      4'd1:    r = {1'b0, a};
      4'd2:    r = {1'b0, a} + {1'b0, b};
      4'd3:    r = {1'b0, b} - {1'b0, a};
      4'd4:    r = {1'b0, a & b};
      4'd5:    r = {1'b0, b} + 9'd1;
      4'd6:    r = {1'b0, b} - 9'd1;
      4'd7:    r = {1'b0, a | b};
      4'd9:    r = {1'b0, a ^ b};
      4'd10:   r = {1'b0, ~b};
      default: r = {1'b1, 5'h1A, bt};
    endcase
    return r;
  endfunction

  always_comb {alu_carry, alu_ans} = alu_fn(alu_inst, alu_a, alu_b, alu_bit);

  task automatic model_reset();
    m_w = RST_W;
    for (int i = 0; i < 8; i++) m_f[i] = 8'h00;
    m_c = 1'b0; m_z = 1'b0; m_ill = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // One full instruction with timing checks; updates the model after retirement.
  task automatic exec(input logic [3:0] op, input logic d, input logic [2:0] bt, input logic [2:0] fa);
    int k;
    logic [8:0] r9;
    logic [7:0] res;
    k = 0;
    while (in_ready !== 1'b1 && k < 8) begin tick(); k++; end
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL exec_ready: in_ready=%b required 1", in_ready);
    end
    r9  = alu_fn(op, m_w, m_f[fa], bt);
    res = (op == 4'd13) ? (m_f[fa] & ~(8'd1 << bt)) :
          (op == 4'd14) ? (m_f[fa] |  (8'd1 << bt)) : r9[7:0];
    in_instr = {op, d, bt, 3'b101, fa};
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_instr = 14'h3FFF;
    n_vec++;
    if ({alu_inst, alu_a, alu_b, alu_bit, in_ready, done} !== {op, m_w, m_f[fa], bt, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL exec_drive op%0d: inst/a/b/bit/rdy/done=%h/%h/%h/%h/%b/%b required %h/%h/%h/%h/0/0",
               op, alu_inst, alu_a, alu_b, alu_bit, in_ready, done, op, m_w, m_f[fa], bt);
    end
    tick();
    dbg_addr = fa; #1;
    n_vec++;
    if ({done, in_ready, alu_inst, dbg_data} !== {1'b1, 1'b0, 4'd8, m_f[fa]}) begin
      n_err++;
      $display("FAIL wb_cycle op%0d: done/rdy/inst/dbg=%b/%b/%h/%h required 1/0/8/%h",
               op, done, in_ready, alu_inst, dbg_data, m_f[fa]);
    end
    @(posedge clk); #1;
    if (op != 4'd8 && op != 4'd15) begin
      if (d) m_f[fa] = res; else m_w = res;
      m_z = (res == 8'h00);
    end
    if (op == 4'd2 || op == 4'd3 || op == 4'd5 || op == 4'd6) m_c = r9[8];
    if (op == 4'd15) m_ill = 1'b1;
    n_vec++;
    if ({done, in_ready, w_out, dbg_data, c_flag, z_flag, illegal} !==
        {1'b0, 1'b1, m_w, m_f[fa], m_c, m_z, m_ill}) begin
      n_err++;
      $display("FAIL retire op%0d: done/rdy/w/f/c/z/ill=%b/%b/%h/%h/%b/%b/%b required 0/1/%h/%h/%b/%b/%b",
               op, done, in_ready, w_out, dbg_data, c_flag, z_flag, illegal,
               m_w, m_f[fa], m_c, m_z, m_ill);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b0; in_instr = 14'h0; dbg_addr = 3'd0;
    model_reset();
    repeat (3) tick();
    reset = 1'b1;
    tick();
    n_vec++;
    if ({in_ready, done, alu_inst, alu_bit, w_out, alu_a, alu_b, c_flag, z_flag, illegal} !==
        {1'b1, 1'b0, 4'd8, 3'd0, RST_W, RST_W, 8'h00, 1'b0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_state: rdy/done/inst/bit/w/a/b/c/z/ill=%b/%b/%h/%h/%h/%h/%h/%b/%b/%b required 1/0/8/0/a5/a5/00/0/0/0",
               in_ready, done, alu_inst, alu_bit, w_out, alu_a, alu_b, c_flag, z_flag, illegal);
    end
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i); #1;
      n_vec++;
      if (dbg_data !== 8'h00) begin
        n_err++; $display("FAIL reset_f%0d: got %h required 00", i, dbg_data);
      end
    end
  endtask

  task automatic test_add();
    for (int b = 4; b < 8; b++) exec(4'd14, 1'b1, 3'(b), 3'd7);
    exec(4'd0, 1'b0, 3'd0, 3'd7);
    exec(4'd14, 1'b1, 3'd5, 3'd2);
    n_vec++;
    if (w_out !== 8'hF0) begin n_err++; $display("FAIL add_setup_w: got %h required f0", w_out); end
    exec(4'd2, 1'b1, 3'd0, 3'd2);
    dbg_addr = 3'd2; #1;
    n_vec++;
    if ({dbg_data, c_flag, z_flag, w_out} !== {8'h10, 1'b1, 1'b0, 8'hF0}) begin
      n_err++;
      $display("FAIL add_result: f2/c/z/w=%h/%b/%b/%h required 10/1/0/f0", dbg_data, c_flag, z_flag, w_out);
    end
  endtask

  task automatic test_sub_borrow();
    for (int b = 0; b < 3; b++) exec(4'd14, 1'b1, 3'(b), 3'd6);
    exec(4'd0, 1'b0, 3'd0, 3'd6);
    exec(4'd14, 1'b1, 3'd0, 3'd1);
    exec(4'd14, 1'b1, 3'd2, 3'd1);
    exec(4'd3, 1'b0, 3'd0, 3'd1);
    dbg_addr = 3'd1; #1;
    n_vec++;
    if ({w_out, c_flag, z_flag, dbg_data} !== {8'hFE, 1'b1, 1'b0, 8'h05}) begin
      n_err++;
      $display("FAIL sub_borrow: w/c/z/f1=%h/%b/%b/%h required fe/1/0/05", w_out, c_flag, z_flag, dbg_data);
    end
  endtask

  task automatic test_inc_bset();
    for (int b = 0; b < 8; b++) exec(4'd14, 1'b1, 3'(b), 3'd3);
    exec(4'd5, 1'b1, 3'd0, 3'd3);
    dbg_addr = 3'd3; #1;
    n_vec++;
    if ({dbg_data, c_flag, z_flag} !== {8'h00, 1'b1, 1'b1}) begin
      n_err++; $display("FAIL inc_wrap: f3/c/z=%h/%b/%b required 00/1/1", dbg_data, c_flag, z_flag);
    end
    exec(4'd14, 1'b1, 3'd7, 3'd3);
    n_vec++;
    if ({dbg_data, c_flag, z_flag} !== {8'h80, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL bset7: f3/c/z=%h/%b/%b required 80/1/0", dbg_data, c_flag, z_flag);
    end
    exec(4'd13, 1'b0, 3'd7, 3'd3);
    n_vec++;
    if ({w_out, dbg_data, z_flag} !== {8'h00, 8'h80, 1'b1}) begin
      n_err++; $display("FAIL bclr_to_w: w/f3/z=%h/%h/%b required 00/80/1", w_out, dbg_data, z_flag);
    end
  endtask

  task automatic test_illegal_backpressure();
    int hs;
    exec(4'd15, 1'b1, 3'd7, 3'd3);
    dbg_addr = 3'd3; #1;
    n_vec++;
    if ({illegal, dbg_data, w_out, c_flag, z_flag} !== {1'b1, 8'h80, 8'h00, 1'b1, 1'b1}) begin
      n_err++;
      $display("FAIL illegal: ill/f3/w/c/z=%b/%h/%h/%b/%b required 1/80/00/1/1",
               illegal, dbg_data, w_out, c_flag, z_flag);
    end
    hs = 0;
    in_instr = {4'd8, 1'b1, 3'd0, 3'b000, 3'd3};
    in_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      n_vec++;
      if ({in_ready, done} !== {(i % 3) == 0, (i % 3) == 2}) begin
        n_err++;
        $display("FAIL backpressure step%0d: rdy/done=%b/%b required %b/%b",
                 i, in_ready, done, (i % 3) == 0, (i % 3) == 2);
      end
      if (in_ready === 1'b1) hs++;
      tick();
    end
    in_valid = 1'b0;
    n_vec++;
    if ({hs, dbg_data, w_out, illegal} !== {32'd3, 8'h80, 8'h00, 1'b1}) begin
      n_err++;
      $display("FAIL backpressure_end: hs/f3/w/ill=%0d/%h/%h/%b required 3/80/00/1", hs, dbg_data, w_out, illegal);
    end
  endtask

  task automatic test_reset_mid();
    dbg_addr = 3'd4; #1;
    in_instr = {4'd14, 1'b1, 3'd0, 3'b000, 3'd4};
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    n_vec++;
    if (done !== 1'b1) begin n_err++; $display("FAIL midreset_wb: done=%b required 1", done); end
    reset = 1'b0; #1;
    n_vec++;
    if ({done, in_ready, alu_inst, w_out, dbg_data, illegal, c_flag, z_flag} !==
        {1'b0, 1'b1, 4'd8, RST_W, 8'h00, 1'b0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL midreset_async: done/rdy/inst/w/f4/ill/c/z=%b/%b/%h/%h/%h/%b/%b/%b required 0/1/8/a5/00/0/0/0",
               done, in_ready, alu_inst, w_out, dbg_data, illegal, c_flag, z_flag);
    end
    tick(); tick();
    reset = 1'b1;
    model_reset();
    n_vec++;
    if ({in_ready, dbg_data} !== {1'b1, 8'h00}) begin
      n_err++; $display("FAIL midreset_release: rdy/f4=%b/%h required 1/00", in_ready, dbg_data);
    end
    tick();
    n_vec++;
    if ({done, dbg_data, w_out} !== {1'b0, 8'h00, RST_W}) begin
      n_err++; $display("FAIL midreset_nowb: done/f4/w=%b/%h/%h required 0/00/a5", done, dbg_data, w_out);
    end
    exec(4'd14, 1'b1, 3'd0, 3'd4);
    n_vec++;
    if ({dbg_data, w_out} !== {8'h01, RST_W}) begin
      n_err++; $display("FAIL after_reset_op: f4/w=%h/%h required 01/a5", dbg_data, w_out);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_borrow();
    test_inc_bset();
    test_illegal_backpressure();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter RESET_W, default 8'h00, the reset value of the working register W.
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-004 SHALL have port in_valid  input  1  instruction word present.
REQ-005 SHALL have port in_instr  input  14  instruction: op[13:10], d[9] (0=W, 1=F), bit[8:6], [5:3] ignored, faddr[2:0].
REQ-006 SHALL have port in_ready  output  1  block can accept an instruction.
REQ-007 SHALL have port alu_inst  output  4  opcode driven to the external ALU.
REQ-008 SHALL have port alu_a  output  8  W value to ALU operand a.
REQ-009 SHALL have port alu_b  output  8  F[faddr] value to ALU operand b.
REQ-010 SHALL have port alu_bit  output  3  bit index to ALU.
REQ-011 SHALL have port alu_ans  input  8  ALU result (combinational from ALU).
REQ-012 SHALL have port alu_carry  input  1  ALU carry/borrow (result bit 8).
REQ-013 SHALL have ports w_out  output  8  (W), c_flag  output  1, z_flag  output  1, illegal  output  1 (sticky).
REQ-014 SHALL have ports dbg_addr  input  3 and dbg_data  output  8, a combinational read of F[dbg_addr].
REQ-015 SHALL have port done  output  1  one-cycle pulse per retired instruction.

Function
REQ-016 SHALL contain W (8 bits) and register file F (8 x 8 bits), plus C and Z flag registers.
REQ-017 SHALL run FSM IDLE -> EXEC -> WB -> IDLE; in_ready=1 only in IDLE; handshake = in_valid & in_ready at a rising edge latches in_instr and enters EXEC.
REQ-018 SHALL in EXEC drive alu_inst=op, alu_a=W, alu_b=F[faddr], alu_bit=bit, and at the EXEC->WB edge capture result and carry into internal registers.
REQ-019 SHALL outside EXEC drive alu_inst=4'b1000 (nop), with alu_a=W, alu_b=F[0], and alu_bit=0.
REQ-020 SHALL compute op 13 (bclr) locally as F[faddr] & ~(1<<bit), and op 14 (bset) locally as F[faddr] | (1<<bit), ignoring alu_ans for these ops.
REQ-021 SHALL in WB write the captured result to W when d=0, or to F[faddr] when d=1, assert done for exactly that cycle, and return to IDLE.
REQ-022 SHALL not write W or F for op 8 (nop) or op 15 (illegal); done still pulses for both.
REQ-023 SHALL update C in WB only for ops 2, 3, 5, 6; C=alu_carry as captured (op 3 computes F-W, and C=1 means borrow).
REQ-024 SHALL update Z in WB for all ops except 8 and 15, with Z=(result[7:0]==0).
REQ-025 SHALL for op 15 set illegal=1 (held until reset), and SHALL leave W, F, C, and Z unchanged.
REQ-026 SHALL give latency handshake-edge N -> EXEC cycle N+1 -> WB cycle N+2 with done=1; updated state is visible at cycle N+3; throughput is 1 instruction per 3 cycles.
REQ-027 SHALL ignore in_valid and in_instr while not in IDLE; no instruction is lost because in_ready=0.
REQ-028 SHALL make a dbg_data read of the address being written in WB return the old value in WB and the new value from the next cycle.

Reset
REQ-029 SHALL on reset=0, immediately and regardless of FSM state, force IDLE, W=RESET_W, F[0..7]=0, C=0, Z=0, illegal=0, done=0, and alu_inst=4'b1000.
REQ-030 SHALL abort any instruction in EXEC or WB when reset asserts, with no partial writeback; after reset releases, in_ready=1 on the first cycle.

Verification
REQ-031 Bench SHALL use a behavioural ALU model and cover these directed scenarios.
REQ-032 Add: W=0xF0, F[2]=0x20, op 2, d=1, faddr=2 -> F[2]=0x10, C=1, Z=0, done pulses exactly 2 cycles after handshake.
REQ-033 Sub with borrow: W=0x07, F[1]=0x05, op 3, d=0 -> W=0xFE, C=1, Z=0.
REQ-034 Inc wrap: F[3]=0xFF, op 5, d=1 -> F[3]=0x00, C=1, Z=1; then bset bit 7 on F[3] -> F[3]=0x80, C unchanged at 1, Z=0.
REQ-035 Illegal and back-pressure: op 15 -> illegal=1, W and F unchanged, done pulses; in_valid held high continuously -> one handshake every 3 cycles, in_ready=0 during EXEC and WB.
REQ-036 Reset mid-operation: assert reset during WB of a d=1 write -> target F entry stays 0, done=0, W=RESET_W, in_ready=1 after release.
